// File: rtl/zbt_arb_pkg.sv
// zbt_arb_pkg: port indices, default widths and the read-tag type shared by the ZBT arbiter.
package zbt_arb_pkg;
  localparam int PORT_DISP = 0;
  localparam int PORT_CAM = 1;
  localparam int PORT_PROC = 2;
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 36;
  typedef struct packed {
    logic       valid;
    logic [1:0] port;
  } tag_t;
endpackage

// File: rtl/zbt_read_tag_pipe.sv
// zbt_read_tag_pipe: shift register carrying read tags in step with the memory read pipeline.
module zbt_read_tag_pipe
  import zbt_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic clr_n,
  input  tag_t tag_i,
  output tag_t tag_o
);
  tag_t [DEPTH-1:0] pipe_q;
  always_ff @(posedge clk)
    pipe_q <= clr_n ? {pipe_q[DEPTH-2:0], tag_i} : '0;
  assign tag_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/zbt_port_arbiter.sv
// zbt_port_arbiter: fixed-priority (0>1>2) ZBT bank arbiter with port-2 anti-starvation promotion.
module zbt_port_arbiter
  import zbt_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        grant,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starved
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_q, wait_d;
  logic promote, sel_we;
  logic [1:0] sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  tag_t tag_in, tag_out;
  assign promote = wait_q == CW'(MAX_WAIT);
  // promotion sits below port 0: display refresh is hard real-time
  always_comb begin
    grant = !reset ? 3'b000 :
            req[PORT_DISP] ? 3'b001 :
            (promote && req[PORT_PROC]) ? 3'b100 :
            req[PORT_CAM] ? 3'b010 :
            req[PORT_PROC] ? 3'b100 : 3'b000;
    sel = grant[PORT_PROC] ? 2'(PORT_PROC) : grant[PORT_CAM] ? 2'(PORT_CAM) : 2'(PORT_DISP);
    sel_addr = grant[PORT_PROC] ? addr2 : grant[PORT_CAM] ? addr1 : addr0;
    sel_wdata = grant[PORT_PROC] ? wdata2 : grant[PORT_CAM] ? wdata1 : wdata0;
    sel_we = we[sel];
    tag_in = '{valid: (|grant) & ~sel_we, port: sel};
    wait_d = (!req[PORT_PROC] || grant[PORT_PROC]) ? '0 : promote ? wait_q : wait_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      rdata <= '0;
      rvalid <= '0;
      starved <= 1'b0;
    end else begin
      wait_q <= wait_d;
      mem_we <= (|grant) & sel_we;
      if (|grant) begin
        mem_addr <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      starved <= grant[PORT_PROC] & promote;
      rvalid <= tag_out.valid ? 3'b001 << tag_out.port : 3'b000;
      if (tag_out.valid) rdata <= mem_rdata;
    end
  end
  // one extra stage covers the command register ahead of the memory pipeline
  zbt_read_tag_pipe #(.DEPTH(READ_LATENCY + 1)) u_tag_pipe (
    .clk  (clk),
    .clr_n(reset),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );
endmodule
